// File: rtl/axi_dacfifo_play_if.sv
// AXI read-channel and DAC-stream bundle for axi_dacfifo_play.
// master: drives AR, rready and the DAC stream; slave: memory/DAC side.
interface axi_dacfifo_play_if #(
   parameter int DATA_WIDTH = 512
);
   logic                  axi_arvalid;
   logic [31:0]           axi_araddr;
   logic [7:0]            axi_arlen;
   logic [2:0]            axi_arsize;
   logic [1:0]            axi_arburst;
   logic [3:0]            axi_arid;
   logic                  axi_arlock;
   logic [3:0]            axi_arcache;
   logic [2:0]            axi_arprot;
   logic [3:0]            axi_arqos;
   logic [3:0]            axi_aruser;
   logic                  axi_arready;
   logic                  axi_rvalid;
   logic [1:0]            axi_rresp;
   logic                  axi_rlast;
   logic [DATA_WIDTH-1:0] axi_rdata;
   logic                  axi_rready;
   logic                  dac_valid;
   logic [DATA_WIDTH-1:0] dac_data;
   logic                  dac_ready;
   logic                  dac_unf;

   modport master (
      output axi_arvalid, axi_araddr, axi_arlen, axi_arsize,
      output axi_arburst, axi_arid, axi_arlock, axi_arcache,
      output axi_arprot, axi_arqos, axi_aruser,
      input  axi_arready,
      input  axi_rvalid, axi_rresp, axi_rlast, axi_rdata,
      output axi_rready,
      output dac_valid, dac_data, dac_unf,
      input  dac_ready
   );

   modport slave (
      input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize,
      input  axi_arburst, axi_arid, axi_arlock, axi_arcache,
      input  axi_arprot, axi_arqos, axi_aruser,
      output axi_arready,
      output axi_rvalid, axi_rresp, axi_rlast, axi_rdata,
      input  axi_rready,
      input  dac_valid, dac_data, dac_unf,
      output dac_ready
   );
endinterface

// File: rtl/axi_dacfifo_play.sv
// DDR waveform playback: AXI INCR read master feeding a FWFT beat FIFO.
// Ports: axi_clk/axi_resetn, play_* control, play_busy, axi_rerror, bus.
module axi_dacfifo_play #(
   parameter int          AXI_DATA_WIDTH  = 512,
   parameter int          AXI_SIZE        = 6,
   parameter int          AXI_LENGTH      = 16,
   parameter logic [31:0] AXI_ADDRESS     = 32'h00000000,
   parameter int          FIFO_DEPTH_LOG2 = 6
) (
   input  logic               axi_clk,
   input  logic               axi_resetn,
   input  logic               play_start,
   input  logic               play_stop,
   input  logic               play_loop,
   input  logic [31:0]        play_last_addr,
   output logic               play_busy,
   output logic               axi_rerror,
   axi_dacfifo_play_if.master bus
);
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 2;
   localparam int BW    = (AXI_LENGTH > 1) ? $clog2(AXI_LENGTH) : 1;

   localparam logic [31:0]   BURST_BYTES = 32'(AXI_LENGTH) << AXI_SIZE;
   localparam logic [CW-1:0] LEN_C       = CW'(AXI_LENGTH);
   localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
   localparam logic [BW-1:0] LAST_BEAT   = BW'(AXI_LENGTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FLUSH
   } state_t;

   state_t state;

   logic [AXI_DATA_WIDTH-1:0]  mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]              level;
   logic [CW-1:0]              outstanding;
   logic [BW-1:0]              beat;
   logic [31:0]                last_burst;
   logic                       ar_hs;
   logic                       r_hs;
   logic                       flowing;
   logic                       fifo_wr;
   logic                       fifo_rd;
   logic                       credit_ok;
   logic                       last_exp;

   assign last_burst = play_last_addr & ~(BURST_BYTES - 32'd1);
   assign ar_hs      = bus.axi_arvalid & bus.axi_arready;
   assign r_hs       = bus.axi_rvalid & bus.axi_rready;
   assign flowing    = (state == RUN) | (state == DRAIN);
   assign fifo_wr    = r_hs & flowing;
   assign fifo_rd    = bus.dac_valid & bus.dac_ready;
   assign last_exp   = (beat == LAST_BEAT);

   // Occupancy counts beats already requested, so the FIFO can never
   // be asked to hold more than it has room for.
   assign credit_ok  = (level + outstanding + LEN_C) <= DEPTH_C;

   assign bus.axi_arlen   = 8'(AXI_LENGTH - 1);
   assign bus.axi_arsize  = 3'(AXI_SIZE);
   assign bus.axi_arburst = 2'b01;
   assign bus.axi_arid    = 4'd0;
   assign bus.axi_arlock  = 1'b0;
   assign bus.axi_arcache = 4'b0011;
   assign bus.axi_arprot  = 3'd0;
   assign bus.axi_arqos   = 4'd0;
   assign bus.axi_aruser  = 4'd0;

   assign play_busy      = (state != IDLE);
   assign bus.axi_rready = (state != IDLE);
   assign bus.dac_valid  = flowing & (level != '0);
   assign bus.dac_data   = bus.dac_valid ? mem[rd_ptr] : '0;
   assign bus.dac_unf    = (state == RUN) & bus.dac_ready
                         & (level == '0);

   always_ff @(posedge axi_clk) begin
      if (fifo_wr) begin
         mem[wr_ptr] <= bus.axi_rdata;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state           <= IDLE;
         bus.axi_arvalid <= 1'b0;
         bus.axi_araddr  <= AXI_ADDRESS;
         axi_rerror      <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         level           <= '0;
         outstanding     <= '0;
         beat            <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (fifo_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level <= level + CW'(fifo_wr) - CW'(fifo_rd);

         outstanding <= outstanding
                      + (ar_hs ? LEN_C : '0)
                      - CW'(r_hs);

         // Beat counter resyncs on rlast so one bad burst does not
         // poison the check of every burst after it.
         if (r_hs) begin
            if ((bus.axi_rlast != last_exp) ||
                (bus.axi_rresp != 2'b00)) begin
               axi_rerror <= 1'b1;
            end
            beat <= (bus.axi_rlast | last_exp) ? '0 : beat + 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (play_start && !play_stop) begin
                  state           <= RUN;
                  bus.axi_arvalid <= 1'b1;
                  bus.axi_araddr  <= AXI_ADDRESS;
                  axi_rerror      <= 1'b0;
                  wr_ptr          <= '0;
                  rd_ptr          <= '0;
                  level           <= '0;
                  beat            <= '0;
               end
            end
            RUN: begin
               if (play_stop) begin
                  state  <= FLUSH;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
                  level  <= '0;
                  if (ar_hs) begin
                     bus.axi_arvalid <= 1'b0;
                  end
               end else if (ar_hs) begin
                  bus.axi_arvalid <= 1'b0;
                  if (bus.axi_araddr == last_burst) begin
                     if (play_loop) begin
                        bus.axi_araddr <= AXI_ADDRESS;
                     end else begin
                        state <= DRAIN;
                     end
                  end else begin
                     bus.axi_araddr <= bus.axi_araddr + BURST_BYTES;
                  end
               end else if (!bus.axi_arvalid && credit_ok) begin
                  bus.axi_arvalid <= 1'b1;
               end
            end
            DRAIN: begin
               if (play_stop) begin
                  state  <= FLUSH;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
                  level  <= '0;
               end else if (outstanding == '0 && level == '0) begin
                  state <= IDLE;
               end
            end
            FLUSH: begin
               if (ar_hs) begin
                  bus.axi_arvalid <= 1'b0;
               end
               if (!bus.axi_arvalid && outstanding == '0) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_dacfifo_play.sv
// Directed bench for axi_dacfifo_play with an AXI memory responder
// and a stream model checked every cycle.
module tb_axi_dacfifo_play;
   localparam int          DW = 512;
   localparam int          L  = 16;
   localparam logic [31:0] BB = 32'h400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        play_start = 1'b0;
   logic        play_stop = 1'b0;
   logic        play_loop = 1'b0;
   logic [31:0] play_last_addr = 32'h800;
   logic        play_busy;
   logic        axi_rerror;

   axi_dacfifo_play_if #(.DATA_WIDTH(DW)) bus ();

   axi_dacfifo_play #(
      .AXI_DATA_WIDTH (DW),
      .AXI_SIZE       (6),
      .AXI_LENGTH     (L),
      .AXI_ADDRESS    (32'h0),
      .FIFO_DEPTH_LOG2(6)
   ) dut (
      .axi_clk       (clk),
      .axi_resetn    (rst_n),
      .play_start    (play_start),
      .play_stop     (play_stop),
      .play_loop     (play_loop),
      .play_last_addr(play_last_addr),
      .play_busy     (play_busy),
      .axi_rerror    (axi_rerror),
      .bus           (bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic ar_rdy_en = 1'b1;
   logic r_en = 1'b1;
   logic dac_rdy = 1'b1;
   int   err_burst = -1;
   int   err_beat = 0;
   int   early_last = -1;

   logic [31:0] ar_q [$];
   int          beat_i = 0;
   int          burst_i = 0;

   int          ar_n = 0;
   int          out_n = 0;
   int          unf_after = 0;
   bit          seen_out = 0;
   int          nb = 1;
   bit          m_loop = 0;
   logic [31:0] ar_log [$];
   logic [31:0] out_w [$];
   bit          prev_arv = 0;
   logic [31:0] prev_addr = '0;

   function automatic logic [DW-1:0] beat_val(logic [31:0] a, int b);
      logic [31:0] w;
      w = a + 32'(b * 64);
      return {(DW/32){w}};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic bus_loop();
      logic [DW-1:0] want;
      logic [31:0]   a_exp;
      forever begin
         @(negedge clk);
         bus.axi_arready = ar_rdy_en;
         bus.dac_ready   = dac_rdy;
         if (ar_q.size() > 0 && r_en) begin
            bus.axi_rvalid = 1'b1;
            bus.axi_rdata  = beat_val(ar_q[0], beat_i);
            bus.axi_rlast  = (early_last >= 0) ? (beat_i == early_last)
                                               : (beat_i == L - 1);
            bus.axi_rresp  = (burst_i == err_burst && beat_i == err_beat)
                           ? 2'b10 : 2'b00;
         end else begin
            bus.axi_rvalid = 1'b0;
            bus.axi_rdata  = '0;
            bus.axi_rlast  = 1'b0;
            bus.axi_rresp  = 2'b00;
         end
         #1;
         if (!rst_n) begin
            ar_q.delete();
            beat_i   = 0;
            burst_i  = 0;
            prev_arv = 0;
         end else begin
            if (play_start && !play_stop && !play_busy) begin
               ar_n      = 0;
               out_n     = 0;
               unf_after = 0;
               seen_out  = 0;
               burst_i   = 0;
               nb        = int'(play_last_addr >> 10) + 1;
               m_loop    = play_loop;
               ar_log.delete();
               out_w.delete();
            end
            if (prev_arv) begin
               chk("ar_hold", {31'd0, bus.axi_arvalid, bus.axi_araddr},
                   {32'd1, prev_addr});
            end
            prev_arv  = bus.axi_arvalid && !bus.axi_arready;
            prev_addr = bus.axi_araddr;
            if (bus.axi_arvalid && bus.axi_arready) begin
               if (!m_loop && ar_n >= nb) begin
                  total++;
                  bad++;
                  $display("FAIL extra_ar: got %0h want none",
                           bus.axi_araddr);
               end else begin
                  a_exp = 32'((ar_n % nb) * 1024);
                  chk("araddr", 64'(bus.axi_araddr), 64'(a_exp));
               end
               ar_n++;
               ar_log.push_back(bus.axi_araddr);
               ar_q.push_back(bus.axi_araddr);
               total++;
               if (ar_n * L - out_n > 64) begin
                  bad++;
                  $display("FAIL credit: got %0d want <=64",
                           ar_n * L - out_n);
               end
            end
            if (bus.axi_rvalid && bus.axi_rready) begin
               beat_i++;
               if (beat_i == L) begin
                  beat_i = 0;
                  burst_i++;
                  void'(ar_q.pop_front());
               end
            end
            if (bus.dac_unf) begin
               if (seen_out) unf_after++;
               if (bus.dac_valid || !bus.dac_ready || !play_busy) begin
                  total++;
                  bad++;
                  $display("FAIL unf_cond: got v=%0b r=%0b b=%0b",
                           bus.dac_valid, bus.dac_ready, play_busy);
               end
            end
            if (bus.dac_valid && bus.dac_ready) begin
               want = beat_val(32'(((out_n / L) % nb) * 1024), out_n % L);
               total++;
               if (bus.dac_data !== want) begin
                  bad++;
                  $display("FAIL dac_data #%0d: got %0h want %0h",
                           out_n, bus.dac_data[63:0], want[63:0]);
               end
               out_w.push_back(bus.dac_data[31:0]);
               out_n++;
               seen_out = 1;
            end
         end
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      play_start = 1'b1;
      @(negedge clk);
      play_start = 1'b0;
   endtask

   task automatic wait_idle(int limit, string nm);
      int c = 0;
      while (play_busy && c < limit) begin
         @(negedge clk);
         c++;
      end
      chk(nm, 64'(play_busy), 64'd0);
   endtask

   task automatic chk_reset(string nm);
      chk({nm, "_arvalid"}, 64'(bus.axi_arvalid), 64'd0);
      chk({nm, "_araddr"}, 64'(bus.axi_araddr), 64'd0);
      chk({nm, "_rready"}, 64'(bus.axi_rready), 64'd0);
      chk({nm, "_dvalid"}, 64'(bus.dac_valid), 64'd0);
      chk({nm, "_ddata"}, bus.dac_data[63:0], 64'd0);
      chk({nm, "_unf"}, 64'(bus.dac_unf), 64'd0);
      chk({nm, "_rerror"}, 64'(axi_rerror), 64'd0);
      chk({nm, "_busy"}, 64'(play_busy), 64'd0);
   endtask

   task automatic run_tests();
      int  c;
      bit  any;

      #1 rst_n = 1'b0;
      #1 chk_reset("rst");
      chk("arlen", 64'(bus.axi_arlen), 64'd15);
      chk("arsize", 64'(bus.axi_arsize), 64'd6);
      chk("arburst", 64'(bus.axi_arburst), 64'd1);
      chk("arcache", 64'(bus.axi_arcache), 64'd3);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // single pass, three bursts
      play_last_addr = 32'h800;
      play_loop = 1'b0;
      dac_rdy = 1'b1;
      pulse_start();
      #2;
      chk("ar_latency_v", 64'(bus.axi_arvalid), 64'd1);
      chk("ar_latency_a", 64'(bus.axi_araddr), 64'd0);
      chk("busy_run", 64'(play_busy), 64'd1);
      wait_idle(400, "t1_idle");
      chk("t1_ar_n", 64'(ar_n), 64'd3);
      chk("t1_ar0", 64'(ar_log[0]), 64'h0);
      chk("t1_ar1", 64'(ar_log[1]), 64'h400);
      chk("t1_ar2", 64'(ar_log[2]), 64'h800);
      chk("t1_out_n", 64'(out_n), 64'd48);
      chk("t1_w17", 64'(out_w[17]), 64'h440);
      chk("t1_w47", 64'(out_w[47]), 64'hBC0);
      chk("t1_unf", 64'(unf_after), 64'd0);
      chk("t1_rerror", 64'(axi_rerror), 64'd0);

      // looping, then stop
      play_loop = 1'b1;
      pulse_start();
      tick(150);
      chk("t2_ar2", 64'(ar_log[2]), 64'h800);
      chk("t2_ar3", 64'(ar_log[3]), 64'h0);
      chk("t2_ar4", 64'(ar_log[4]), 64'h400);
      @(negedge clk);
      play_stop = 1'b1;
      @(negedge clk);
      play_stop = 1'b0;
      #2;
      chk("t2_flush_valid", 64'(bus.dac_valid), 64'd0);
      wait_idle(200, "t2_idle");
      chk("t2_unf", 64'(unf_after), 64'd0);

      // back-pressure: credits cap requests at one FIFO's worth
      play_loop = 1'b0;
      play_last_addr = 32'h2000;
      dac_rdy = 1'b0;
      pulse_start();
      tick(200);
      chk("t3_ar_cap", 64'(ar_n), 64'd4);
      chk("t3_out0", 64'(out_n), 64'd0);
      chk("t3_valid", 64'(bus.dac_valid), 64'd1);
      dac_rdy = 1'b1;
      wait_idle(1000, "t3_idle");
      chk("t3_ar_n", 64'(ar_n), 64'd9);
      chk("t3_out_n", 64'(out_n), 64'd144);

      // bad response is sticky until the next start
      play_last_addr = 32'h800;
      err_burst = 1;
      err_beat = 5;
      pulse_start();
      wait_idle(400, "t4_idle");
      chk("t4_rerror", 64'(axi_rerror), 64'd1);
      tick(5);
      chk("t4_sticky", 64'(axi_rerror), 64'd1);
      err_burst = -1;
      pulse_start();
      #2;
      chk("t4_clear", 64'(axi_rerror), 64'd0);
      wait_idle(400, "t4b_idle");
      chk("t4b_rerror", 64'(axi_rerror), 64'd0);

      // start and stop together in IDLE
      @(negedge clk);
      play_start = 1'b1;
      play_stop = 1'b1;
      @(negedge clk);
      play_start = 1'b0;
      play_stop = 1'b0;
      any = 0;
      for (int i = 0; i < 10; i++) begin
         #2;
         any |= bus.axi_arvalid | play_busy;
         @(negedge clk);
      end
      chk("t6_no_run", 64'(any), 64'd0);

      // early rlast, then async reset mid-burst
      play_loop = 1'b1;
      early_last = 14;
      pulse_start();
      c = 0;
      while (!axi_rerror && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("t5_rerror", 64'(axi_rerror), 64'd1);
      tick(3);
      #2;
      chk("t5_midburst", 64'(bus.axi_rvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_reset("t5_rst");
      tick(2);
      early_last = -1;
      rst_n = 1'b1;
      tick(2);

      // low address bits ignored: one burst only
      play_loop = 1'b0;
      play_last_addr = 32'h3FF;
      pulse_start();
      wait_idle(200, "t7_idle");
      chk("t7_ar_n", 64'(ar_n), 64'd1);
      chk("t7_out_n", 64'(out_n), 64'd16);
      chk("t7_w15", 64'(out_w[15]), 64'h3C0);

      tick(2);
   endtask

   initial begin
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b0;
      bus.axi_rdata   = '0;
      bus.axi_rlast   = 1'b0;
      bus.axi_rresp   = 2'b00;
      bus.dac_ready   = 1'b0;
      fork
         bus_loop();
         run_tests();
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi_dacfifo_play.md
Name:
axi_dacfifo_play

Overview:
Single-clock AXI read master that replays a waveform previously stored in PL DDR and streams it toward the DAC path. It is the playback counterpart of the ADC capture path: it issues INCR read bursts from AXI_ADDRESS up to a programmed last-burst address, buffers the returned beats in an internal FIFO, and presents them on a valid/ready stream, optionally looping forever.

Parameters:
AXI_DATA_WIDTH, 512, width of axi_rdata and dac_data in bits
AXI_SIZE, 6, log2 bytes per beat; driven on axi_arsize; must equal log2(AXI_DATA_WIDTH/8)
AXI_LENGTH, 16, beats per burst; axi_arlen = AXI_LENGTH-1; BURST_BYTES = AXI_LENGTH << AXI_SIZE
AXI_ADDRESS, 32'h00000000, start byte address of the stored waveform; BURST_BYTES aligned
FIFO_DEPTH_LOG2, 6, log2 of internal beat FIFO depth; must be >= log2(AXI_LENGTH)+1

Ports:
axi_clk  in  1  sole clock
axi_resetn  in  1  asynchronous, active-low reset
play_start  in  1  single-cycle pulse; starts playback (honoured only in IDLE)
play_stop  in  1  single-cycle pulse; aborts playback
play_loop  in  1  level, sampled at each wrap decision; 1 = restart at AXI_ADDRESS after last burst
play_last_addr  in  32  byte address of the first byte of the final burst; low log2(BURST_BYTES) bits ignored
play_busy  out  1  high in any state other than IDLE
axi_arvalid  out  1  read address valid
axi_araddr  out  32  burst start address
axi_arlen  out  8  constant AXI_LENGTH-1
axi_arsize  out  3  constant AXI_SIZE
axi_arburst  out  2  constant 2'b01 (INCR)
axi_arid/arlock/arcache/arprot/arqos/aruser  out  4/1/4/3/4/4  constants 0/0/4'b0011/0/0/0
axi_arready  in  1  read address ready
axi_rvalid  in  1  read data valid
axi_rresp  in  2  read response
axi_rlast  in  1  last beat of burst
axi_rdata  in  AXI_DATA_WIDTH  read data
axi_rready  out  1  read data ready
dac_valid  out  1  output beat valid
dac_data  out  AXI_DATA_WIDTH  output beat
dac_ready  in  1  downstream accepts beat when dac_valid & dac_ready
dac_unf  out  1  one-cycle pulse: dac_ready high, FIFO empty, state RUN
axi_rerror  out  1  sticky: any accepted beat with rresp!=0 or rlast mismatch; cleared by play_start

Behaviour:
- Reset (axi_resetn low, async): state IDLE, axi_arvalid=0, axi_araddr=AXI_ADDRESS, axi_rready=0, dac_valid=0, dac_data=0, dac_unf=0, axi_rerror=0, play_busy=0, FIFO empty, outstanding=0. Any in-flight AXI transaction is abandoned; axi_resetn is shared with the interconnect reset.
- States: IDLE, RUN, DRAIN, FLUSH.
- IDLE: play_start -> RUN; araddr <= AXI_ADDRESS; axi_rerror <= 0; FIFO cleared. play_start and play_stop asserted together in IDLE -> remain IDLE.
- Credits: occupancy = FIFO level + outstanding beats (outstanding += AXI_LENGTH on AR handshake, -= 1 per accepted R beat). In RUN, arvalid asserts only when occupancy + AXI_LENGTH <= 2^FIFO_DEPTH_LOG2. Once asserted, arvalid holds with stable araddr until arready (AXI rule), even if play_stop arrives.
- AR latency: play_start in cycle N -> arvalid=1, araddr=AXI_ADDRESS in cycle N+1.
- After each AR handshake: if araddr == last burst address (play_last_addr masked), then play_loop=1 -> araddr <= AXI_ADDRESS and stay in RUN; play_loop=0 -> DRAIN. Otherwise araddr <= araddr + BURST_BYTES (32-bit wrap, no limit check).
- axi_rready = 1 in RUN, DRAIN and FLUSH; the credit rule guarantees FIFO space. Beats are written on rvalid & rready.
- Beat counter per burst checks rlast: rlast on a beat other than beat AXI_LENGTH-1, or missing on it, sets axi_rerror. rresp!=0 also sets axi_rerror. Data is still forwarded.
- FIFO is first-word-fall-through: dac_valid rises the cycle after the first beat is written. Simultaneous write and read keep the level unchanged. dac_data holds while dac_valid & !dac_ready.
- DRAIN: no new AR; wait for outstanding==0 and FIFO empty (all beats consumed by DAC) -> IDLE.
- play_stop in RUN or DRAIN -> FLUSH. FLUSH: finish any pending AR handshake; accept and discard all R beats; dac_valid forced 0; FIFO cleared; when outstanding==0 and arvalid==0 -> IDLE. play_start outside IDLE is ignored.
- dac_unf pulses only in RUN; never in DRAIN, FLUSH or IDLE.

Test Plan:
- Defaults, play_last_addr=0x800, loop=0, start, arready/rvalid always 1 -> 3 ARs at 0x0, 0x400, 0x800; 48 beats out in order; IDLE after last beat taken; no dac_unf after first beat.
- Same as above with loop=1, dac_ready=1 -> araddr sequence 0x0, 0x400, 0x800, 0x0, ...; continuous stream; play_stop -> FLUSH, dac_valid=0, IDLE once outstanding=0.
- dac_ready=0 for 200 cycles -> at most 4 ARs issued (64-beat FIFO), no overflow; release -> data in order.
- rresp=2'b10 on beat 5 of burst 1 -> axi_rerror=1 and stays sticky; next play_start clears it.
- rlast asserted on beat 14 -> axi_rerror=1. Async reset asserted mid-burst -> all outputs at their reset values immediately.
- play_start together with play_stop in IDLE -> no AR issued, play_busy stays 0.
